// File: rtl/ysyx_23060332_exu_mc_pkg.sv
// Shared encodings for the multi-cycle execute unit: op codes, jump kinds,
// branch func3 values and FSM states.
package ysyx_23060332_exu_mc_pkg;

  localparam logic [4:0] EXU_OP_ADD    = 5'd0;
  localparam logic [4:0] EXU_OP_SUB    = 5'd1;
  localparam logic [4:0] EXU_OP_SLL    = 5'd2;
  localparam logic [4:0] EXU_OP_SLT    = 5'd3;
  localparam logic [4:0] EXU_OP_SLTU   = 5'd4;
  localparam logic [4:0] EXU_OP_XOR    = 5'd5;
  localparam logic [4:0] EXU_OP_SRL    = 5'd6;
  localparam logic [4:0] EXU_OP_SRA    = 5'd7;
  localparam logic [4:0] EXU_OP_OR     = 5'd8;
  localparam logic [4:0] EXU_OP_AND    = 5'd9;
  localparam logic [4:0] EXU_OP_LUI    = 5'd10;
  localparam logic [4:0] EXU_OP_MUL    = 5'd11;
  localparam logic [4:0] EXU_OP_MULH   = 5'd12;
  localparam logic [4:0] EXU_OP_MULHSU = 5'd13;
  localparam logic [4:0] EXU_OP_MULHU  = 5'd14;
  localparam logic [4:0] EXU_OP_DIV    = 5'd15;
  localparam logic [4:0] EXU_OP_DIVU   = 5'd16;
  localparam logic [4:0] EXU_OP_REM    = 5'd17;
  localparam logic [4:0] EXU_OP_REMU   = 5'd18;

  localparam logic [1:0] JMP_NONE   = 2'd0;
  localparam logic [1:0] JMP_JAL    = 2'd1;
  localparam logic [1:0] JMP_JALR   = 2'd2;
  localparam logic [1:0] JMP_BRANCH = 2'd3;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } exu_state_e;

  function automatic logic op_is_legal(input logic [4:0] op);
    return op <= EXU_OP_REMU;
  endfunction

  function automatic logic op_is_muldiv(input logic [4:0] op);
    return (op >= EXU_OP_MUL) && (op <= EXU_OP_REMU);
  endfunction

  function automatic logic op_is_div(input logic [4:0] op);
    return (op >= EXU_OP_DIV) && (op <= EXU_OP_REMU);
  endfunction

endpackage

// File: rtl/ysyx_23060332_muldiv.sv
// Iterative engine: shift-add multiply or restoring divide, one bit per cycle,
// on operand magnitudes with the sign fixed up on the final result.
module ysyx_23060332_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_flush,
  input  logic              i_is_div,
  input  logic              i_a_signed,
  input  logic              i_b_signed,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [2*XLEN-1:0] o_acc
);

  logic              r_busy;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;

  logic              w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [XLEN:0]     w_div_shift, w_trial;
  logic              w_q_bit;
  logic [2*XLEN-1:0] w_div_nxt;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [XLEN-1:0]   w_rem, w_quo;

  assign w_a_neg = i_a_signed && i_a[XLEN-1];
  assign w_b_neg = i_b_signed && i_b[XLEN-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // Multiply: acc = {hi, lo}; lo starts as the multiplier and is shifted out.
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};

  // Divide: acc = {rem, quo}; quotient bits enter at the bottom.
  assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
  assign w_trial     = w_div_shift - {1'b0, r_b};
  assign w_q_bit     = ~w_trial[XLEN];
  assign w_div_nxt   = {(w_q_bit ? w_trial[XLEN-1:0] : w_div_shift[XLEN-1:0]),
                        r_acc[XLEN-2:0], w_q_bit};

  assign w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;
  assign w_rem     = w_acc_nxt[2*XLEN-1:XLEN];
  assign w_quo     = w_acc_nxt[XLEN-1:0];

  // Result is taken combinationally from the last iteration so the caller
  // can latch it in the same cycle o_done is high.
  always_comb begin
    o_acc = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    if (r_is_div) begin
      o_acc = {(r_neg_r ? -w_rem : w_rem), (r_neg_q ? -w_quo : w_quo)};
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CNT_W'(XLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_is_div <= i_is_div;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_b      <= w_b_mag;
      r_acc    <= {{XLEN{1'b0}}, w_a_mag};
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060332_exu_mc.sv
// Multi-cycle execute unit: handshake FSM, single-cycle ALU, jump resolution,
// and an iterative mul/div engine for the M extension.
module ysyx_23060332_exu_mc
  import ysyx_23060332_exu_mc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = $clog2(XLEN) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         op_i,
  input  logic [1:0]         jmp_type_i,
  input  logic [2:0]         br_cond_i,
  input  logic [XLEN-1:0]    op1_i,
  input  logic [XLEN-1:0]    op2_i,
  input  logic [XLEN-1:0]    op1_jump_i,
  input  logic [XLEN-1:0]    op2_jump_i,
  input  logic               reg_wen_i,
  input  logic [RADDR_W-1:0] waddr_i,
  input  logic               flush_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    wdata_o,
  output logic [RADDR_W-1:0] waddr_o,
  output logic               reg_wen_o,
  output logic               jump_en_o,
  output logic [XLEN-1:0]    jump_addr_o,
  output logic [1:0]         dbg_state_o
);

  localparam int SHAMT_W = $clog2(XLEN);

  exu_state_e         r_state, w_state_nxt;
  logic [4:0]         r_op;
  logic [XLEN-1:0]    r_wdata;
  logic [RADDR_W-1:0] r_waddr;
  logic               r_reg_wen;
  logic               r_jump_en;
  logic [XLEN-1:0]    r_jump_addr;

  logic               w_accept;
  logic               w_op_legal, w_is_md, w_is_div, w_is_rem, w_is_sdiv;
  logic               w_div_zero, w_div_ovf, w_md_start;
  logic               w_a_signed, w_b_signed;
  logic               w_md_busy, w_md_done;
  logic [2*XLEN-1:0]  w_md_acc;
  logic [XLEN-1:0]    w_md_result;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]    w_alu, w_fast_wdata;
  logic               w_br_taken;
  logic [XLEN-1:0]    w_jsum, w_jaddr;
  logic               w_jen;

  assign w_op_legal = op_is_legal(op_i);
  assign w_is_md    = op_is_muldiv(op_i);
  assign w_is_div   = op_is_div(op_i);
  assign w_is_rem   = (op_i == EXU_OP_REM) || (op_i == EXU_OP_REMU);
  assign w_is_sdiv  = (op_i == EXU_OP_DIV) || (op_i == EXU_OP_REM);
  assign w_a_signed = (op_i == EXU_OP_MULH) || (op_i == EXU_OP_MULHSU) || w_is_sdiv;
  assign w_b_signed = (op_i == EXU_OP_MULH) || w_is_sdiv;

  // Divide-by-zero and signed overflow finish immediately without iterating.
  assign w_div_zero = w_is_div && (op2_i == '0);
  assign w_div_ovf  = w_is_sdiv && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&op2_i);
  assign w_md_start = w_accept && w_is_md && !w_div_zero && !w_div_ovf;

  // Nothing enters while flushing or in reset; a finished result must be
  // consumed in the same cycle as a new op is accepted.
  assign in_ready  = rst_n && !flush_i &&
                     ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == ST_DONE);

  assign w_shamt = op2_i[SHAMT_W-1:0];

  always_comb begin
    w_alu = '0;
    case (op_i)
      EXU_OP_ADD:  w_alu = op1_i + op2_i;
      EXU_OP_SUB:  w_alu = op1_i - op2_i;
      EXU_OP_SLL:  w_alu = op1_i << w_shamt;
      EXU_OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
      EXU_OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (op1_i < op2_i)};
      EXU_OP_XOR:  w_alu = op1_i ^ op2_i;
      EXU_OP_SRL:  w_alu = op1_i >> w_shamt;
      EXU_OP_SRA:  w_alu = $unsigned($signed(op1_i) >>> w_shamt);
      EXU_OP_OR:   w_alu = op1_i | op2_i;
      EXU_OP_AND:  w_alu = op1_i & op2_i;
      EXU_OP_LUI:  w_alu = op2_i;
      default:     w_alu = '0;
    endcase
  end

  always_comb begin
    w_br_taken = 1'b0;
    case (br_cond_i)
      BR_BEQ:  w_br_taken = (op1_i == op2_i);
      BR_BNE:  w_br_taken = (op1_i != op2_i);
      BR_BLT:  w_br_taken = ($signed(op1_i) < $signed(op2_i));
      BR_BGE:  w_br_taken = ($signed(op1_i) >= $signed(op2_i));
      BR_BLTU: w_br_taken = (op1_i < op2_i);
      BR_BGEU: w_br_taken = (op1_i >= op2_i);
      default: w_br_taken = 1'b0;
    endcase
  end

  assign w_jsum = op1_jump_i + op2_jump_i;

  always_comb begin
    w_jen   = 1'b0;
    w_jaddr = '0;
    if (w_op_legal) begin
      case (jmp_type_i)
        JMP_JAL:    begin w_jen = 1'b1;       w_jaddr = w_jsum; end
        JMP_JALR:   begin w_jen = 1'b1;       w_jaddr = {w_jsum[XLEN-1:1], 1'b0}; end
        JMP_BRANCH: begin w_jen = w_br_taken; w_jaddr = w_jsum; end
        JMP_NONE:   begin w_jen = 1'b0;       w_jaddr = '0; end
        default:    begin w_jen = 1'b0;       w_jaddr = '0; end
      endcase
    end
  end

  always_comb begin
    w_fast_wdata = '0;
    if (w_div_zero) begin
      w_fast_wdata = w_is_rem ? op1_i : '1;
    end else if (w_div_ovf) begin
      w_fast_wdata = w_is_rem ? '0 : op1_i;
    end else if (w_op_legal && !w_is_md && (jmp_type_i != JMP_BRANCH)) begin
      w_fast_wdata = w_alu;
    end
  end

  ysyx_23060332_muldiv #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_md_start),
    .i_flush    (flush_i),
    .i_is_div   (w_is_div),
    .i_a_signed (w_a_signed),
    .i_b_signed (w_b_signed),
    .i_a        (op1_i),
    .i_b        (op2_i),
    .o_busy     (w_md_busy),
    .o_done     (w_md_done),
    .o_acc      (w_md_acc)
  );

  // MUL and quotients live in the low half; MULH* and remainders in the high half.
  assign w_md_result = ((r_op == EXU_OP_MUL) || (r_op == EXU_OP_DIV) || (r_op == EXU_OP_DIVU))
                       ? w_md_acc[XLEN-1:0] : w_md_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            w_state_nxt = w_md_start ? (w_is_div ? ST_DIV : ST_MUL) : ST_DONE;
          end else if ((r_state == ST_DONE) && out_ready) begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_md_done) begin
            w_state_nxt = ST_DONE;
          end else if (!w_md_busy) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output registers only change on accept or engine completion, so they
  // hold steady while a result waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= '0;
      r_wdata     <= '0;
      r_waddr     <= '0;
      r_reg_wen   <= 1'b0;
      r_jump_en   <= 1'b0;
      r_jump_addr <= '0;
    end else if (!flush_i) begin
      if (w_accept) begin
        r_op        <= op_i;
        r_wdata     <= w_fast_wdata;
        r_waddr     <= waddr_i;
        r_reg_wen   <= w_op_legal && reg_wen_i && (jmp_type_i != JMP_BRANCH);
        r_jump_en   <= w_jen;
        r_jump_addr <= w_jaddr;
      end else if (w_md_done) begin
        r_wdata <= w_md_result;
      end
    end
  end

  assign wdata_o     = r_wdata;
  assign waddr_o     = r_waddr;
  assign reg_wen_o   = r_reg_wen;
  assign jump_en_o   = r_jump_en;
  assign jump_addr_o = r_jump_addr;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ysyx_23060332_exu_mc.sv
// Directed bench for the multi-cycle EXU: a vector table for single ops and
// hand-written sequences for back-to-back, stall, flush and reset cases.
module tb_ysyx_23060332_exu_mc;
  import ysyx_23060332_exu_mc_pkg::*;

  localparam int XLEN   = 32;
  localparam int LAT_MD = XLEN + 1;

  logic            clk, rst_n;
  logic            in_valid, in_ready;
  logic [4:0]      op_i;
  logic [1:0]      jmp_type_i;
  logic [2:0]      br_cond_i;
  logic [XLEN-1:0] op1_i, op2_i, op1_jump_i, op2_jump_i;
  logic            reg_wen_i;
  logic [4:0]      waddr_i;
  logic            flush_i;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] wdata_o, jump_addr_o;
  logic [4:0]      waddr_o;
  logic            reg_wen_o, jump_en_o;
  logic [1:0]      dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_23060332_exu_mc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_i(op_i), .jmp_type_i(jmp_type_i), .br_cond_i(br_cond_i),
    .op1_i(op1_i), .op2_i(op2_i), .op1_jump_i(op1_jump_i), .op2_jump_i(op2_jump_i),
    .reg_wen_i(reg_wen_i), .waddr_i(waddr_i), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready), .wdata_o(wdata_o),
    .waddr_o(waddr_o), .reg_wen_o(reg_wen_o), .jump_en_o(jump_en_o),
    .jump_addr_o(jump_addr_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [4:0]  op;
    logic [1:0]  jmp;
    logic [2:0]  br;
    logic [31:0] op1, op2, op1j, op2j;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] e_wdata;
    logic        e_wen;
    logic        e_jen;
    logic [31:0] e_jaddr;
    int          e_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [4:0] op, logic [1:0] jmp, logic [2:0] br,
                              logic [31:0] op1, logic [31:0] op2,
                              logic [31:0] op1j, logic [31:0] op2j,
                              logic wen, logic [4:0] wa, logic [31:0] ew,
                              logic ewen, logic ejen, logic [31:0] eja, int elat);
    vec_t v;
    v.op = op; v.jmp = jmp; v.br = br; v.op1 = op1; v.op2 = op2;
    v.op1j = op1j; v.op2j = op2j; v.wen = wen; v.waddr = wa;
    v.e_wdata = ew; v.e_wen = ewen; v.e_jen = ejen; v.e_jaddr = eja; v.e_lat = elat;
    return v;
  endfunction

  // scoreboard compare
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // driver
  task automatic drive(input vec_t v);
    op_i = v.op; jmp_type_i = v.jmp; br_cond_i = v.br;
    op1_i = v.op1; op2_i = v.op2; op1_jump_i = v.op1j; op2_jump_i = v.op2j;
    reg_wen_i = v.wen; waddr_i = v.waddr; in_valid = 1'b1;
  endtask

  // Issue one op, then return at the first negedge with out_valid high.
  task automatic send(input vec_t v, input string tag, output int lat, output int rdy_seen);
    int n;
    @(negedge clk);
    drive(v);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    rdy_seen = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) rdy_seen++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, rdy;
    send(v, tag, lat, rdy);
    check({tag, "_lat"}, lat, v.e_lat);
    check({tag, "_busy_rdy"}, rdy, 0);
    check({tag, "_wdata"}, wdata_o, v.e_wdata);
    check({tag, "_waddr"}, waddr_o, v.waddr);
    check({tag, "_wen"}, reg_wen_o, v.e_wen);
    check({tag, "_jen"}, jump_en_o, v.e_jen);
    check({tag, "_jaddr"}, jump_addr_o, v.e_jaddr);
  endtask

  initial begin
    vec_t v;
    int   lat, rdy, seen;

    // Vector table: op jmp br op1 op2 op1j op2j wen waddr | wdata wen jen jaddr lat
    vecs.push_back(mk(EXU_OP_ADD,  JMP_NONE, 3'd0, 32'd5, 32'hFFFF_FFFF, 0, 0, 1, 5'd3, 32'd4, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_SUB,  JMP_NONE, 3'd0, 32'd3, 32'd5, 0, 0, 1, 5'd4, 32'hFFFF_FFFE, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_SLL,  JMP_NONE, 3'd0, 32'd1, 32'h21, 0, 0, 1, 5'd5, 32'd2, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_SRA,  JMP_NONE, 3'd0, 32'h8000_0000, 32'd4, 0, 0, 1, 5'd6, 32'hF800_0000, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_SRL,  JMP_NONE, 3'd0, 32'h8000_0000, 32'd31, 0, 0, 1, 5'd7, 32'd1, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_SLT,  JMP_NONE, 3'd0, 32'hFFFF_FFFF, 32'd1, 0, 0, 1, 5'd8, 32'd1, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_SLTU, JMP_NONE, 3'd0, 32'hFFFF_FFFF, 32'd1, 0, 0, 1, 5'd9, 32'd0, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_XOR,  JMP_NONE, 3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 1, 5'd10, 32'h0FF0_0FF0, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_OR,   JMP_NONE, 3'd0, 32'h00FF_0000, 32'h0000_F00F, 0, 0, 1, 5'd11, 32'h00FF_F00F, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_AND,  JMP_NONE, 3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 1, 5'd12, 32'hF000_F000, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_LUI,  JMP_NONE, 3'd0, 32'd123, 32'h1234_5000, 0, 0, 1, 5'd13, 32'h1234_5000, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_MUL,    JMP_NONE, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 5'd14, 32'd1, 1, 0, 0, LAT_MD));
    vecs.push_back(mk(EXU_OP_MUL,    JMP_NONE, 3'd0, 32'hFFFF_FFFD, 32'd5, 0, 0, 1, 5'd15, 32'hFFFF_FFF1, 1, 0, 0, LAT_MD));
    vecs.push_back(mk(EXU_OP_MULH,   JMP_NONE, 3'd0, 32'h8000_0000, 32'h8000_0000, 0, 0, 1, 5'd16, 32'h4000_0000, 1, 0, 0, LAT_MD));
    vecs.push_back(mk(EXU_OP_MULH,   JMP_NONE, 3'd0, 32'hFFFF_FFFD, 32'd5, 0, 0, 1, 5'd17, 32'hFFFF_FFFF, 1, 0, 0, LAT_MD));
    vecs.push_back(mk(EXU_OP_MULHU,  JMP_NONE, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 5'd18, 32'hFFFF_FFFE, 1, 0, 0, LAT_MD));
    vecs.push_back(mk(EXU_OP_MULHSU, JMP_NONE, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 5'd19, 32'hFFFF_FFFF, 1, 0, 0, LAT_MD));
    vecs.push_back(mk(EXU_OP_DIV,  JMP_NONE, 3'd0, 32'd7, 32'd0, 0, 0, 1, 5'd20, 32'hFFFF_FFFF, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_REM,  JMP_NONE, 3'd0, 32'd7, 32'd0, 0, 0, 1, 5'd21, 32'd7, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_DIVU, JMP_NONE, 3'd0, 32'd7, 32'd0, 0, 0, 1, 5'd22, 32'hFFFF_FFFF, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_DIV,  JMP_NONE, 3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 5'd23, 32'h8000_0000, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_REM,  JMP_NONE, 3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 5'd24, 32'd0, 1, 0, 0, 1));
    vecs.push_back(mk(EXU_OP_DIV,  JMP_NONE, 3'd0, 32'hFFFF_FFF9, 32'd2, 0, 0, 1, 5'd25, 32'hFFFF_FFFD, 1, 0, 0, LAT_MD));
    vecs.push_back(mk(EXU_OP_REM,  JMP_NONE, 3'd0, 32'hFFFF_FFF9, 32'd2, 0, 0, 1, 5'd26, 32'hFFFF_FFFF, 1, 0, 0, LAT_MD));
    vecs.push_back(mk(EXU_OP_DIV,  JMP_NONE, 3'd0, 32'd7, 32'hFFFF_FFFE, 0, 0, 1, 5'd27, 32'hFFFF_FFFD, 1, 0, 0, LAT_MD));
    vecs.push_back(mk(EXU_OP_REM,  JMP_NONE, 3'd0, 32'd7, 32'hFFFF_FFFE, 0, 0, 1, 5'd28, 32'd1, 1, 0, 0, LAT_MD));
    vecs.push_back(mk(EXU_OP_DIVU, JMP_NONE, 3'd0, 32'd100, 32'd7, 0, 0, 1, 5'd29, 32'd14, 1, 0, 0, LAT_MD));
    vecs.push_back(mk(EXU_OP_REMU, JMP_NONE, 3'd0, 32'd100, 32'd7, 0, 0, 1, 5'd30, 32'd2, 1, 0, 0, LAT_MD));
    vecs.push_back(mk(EXU_OP_DIVU, JMP_NONE, 3'd0, 32'hFFFF_FFFF, 32'd1, 0, 0, 1, 5'd31, 32'hFFFF_FFFF, 1, 0, 0, LAT_MD));
    vecs.push_back(mk(EXU_OP_ADD, JMP_JAL,  3'd0, 32'h1000, 32'd4, 32'h1000, 32'h20, 1, 5'd1, 32'h1004, 1, 1, 32'h1020, 1));
    vecs.push_back(mk(EXU_OP_ADD, JMP_JALR, 3'd0, 32'h8000_0000, 32'd4, 32'h8000_0003, 32'd0, 1, 5'd2,
                      32'h8000_0004, 1, 1, 32'h8000_0002, 1));
    vecs.push_back(mk(EXU_OP_ADD, JMP_BRANCH, BR_BLT,  32'hFFFF_FFFF, 32'd1, 32'h100, 32'h8, 1, 5'd3, 0, 0, 1, 32'h108, 1));
    vecs.push_back(mk(EXU_OP_ADD, JMP_BRANCH, BR_BGE,  32'hFFFF_FFFF, 32'd1, 32'h100, 32'h8, 1, 5'd4, 0, 0, 0, 32'h108, 1));
    vecs.push_back(mk(EXU_OP_ADD, JMP_BRANCH, BR_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h8, 1, 5'd5, 0, 0, 0, 32'h108, 1));
    vecs.push_back(mk(EXU_OP_ADD, JMP_BRANCH, BR_BGEU, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h8, 1, 5'd6, 0, 0, 1, 32'h108, 1));
    vecs.push_back(mk(EXU_OP_ADD, JMP_BRANCH, BR_BEQ,  32'd5, 32'd5, 32'h200, 32'h4, 1, 5'd7, 0, 0, 1, 32'h204, 1));
    vecs.push_back(mk(EXU_OP_ADD, JMP_BRANCH, BR_BNE,  32'd5, 32'd5, 32'h200, 32'h4, 1, 5'd8, 0, 0, 0, 32'h204, 1));
    vecs.push_back(mk(5'd31, JMP_JAL, 3'd0, 32'd9, 32'd9, 32'h300, 32'h4, 1, 5'd9, 0, 0, 0, 0, 1));

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush_i = 1'b0;
    op_i = '0; jmp_type_i = '0; br_cond_i = '0; op1_i = '0; op2_i = '0;
    op1_jump_i = '0; op2_jump_i = '0; reg_wen_i = 1'b0; waddr_i = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_wen", reg_wen_o, 0);
    check("rst_jen", jump_en_o, 0);
    check("rst_jaddr", jump_addr_o, 0);
    check("rst_state", dbg_state_o, ST_IDLE);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Back-to-back ADDs at one op per cycle
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        check($sformatf("b2b%0d_valid", i), out_valid, 1);
        check($sformatf("b2b%0d_wdata", i), wdata_o, 32'd100 + 32'(i - 1));
      end
      if (i < 4) begin
        check($sformatf("b2b%0d_in_ready", i), in_ready, 1);
        v = mk(EXU_OP_ADD, JMP_NONE, 3'd0, 32'(i), 32'd100, 0, 0, 1, 5'd1, 0, 0, 0, 0, 1);
        drive(v);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Output stall: result held for 3 cycles, next op accepted on release
    out_ready = 1'b0;
    v = mk(EXU_OP_ADD, JMP_NONE, 3'd0, 32'd2, 32'd3, 0, 0, 1, 5'd11, 0, 0, 0, 0, 1);
    send(v, "stall_first", lat, rdy);
    check("stall_first_lat", lat, 1);
    v = mk(EXU_OP_ADD, JMP_NONE, 3'd0, 32'd10, 32'd10, 0, 0, 1, 5'd12, 0, 0, 0, 0, 1);
    drive(v);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", i), out_valid, 1);
      check($sformatf("stall%0d_wdata", i), wdata_o, 32'd5);
      check($sformatf("stall%0d_waddr", i), waddr_o, 5'd11);
      check($sformatf("stall%0d_in_ready", i), in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("release_valid", out_valid, 1);
    check("release_wdata", wdata_o, 32'd20);
    check("release_waddr", waddr_o, 5'd12);
    @(negedge clk);

    // Flush in the middle of a DIVU
    v = mk(EXU_OP_DIVU, JMP_NONE, 3'd0, 32'd100, 32'd7, 0, 0, 1, 5'd2, 0, 0, 0, 0, 1);
    drive(v);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_flush_state", dbg_state_o, ST_DIV);
    flush_i = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_state", dbg_state_o, ST_IDLE);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("flush_no_valid", seen, 0);

    // Asynchronous reset in the middle of a MUL
    v = mk(EXU_OP_MUL, JMP_NONE, 3'd0, 32'd3, 32'd5, 0, 0, 1, 5'd6, 0, 0, 0, 0, 1);
    drive(v);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_state", dbg_state_o, ST_MUL);
    rst_n = 1'b0;
    #1;
    check("midrst_state", dbg_state_o, ST_IDLE);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_waddr", waddr_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_valid", seen, 0);
    check("midrst_idle", dbg_state_o, ST_IDLE);
    run_vec(mk(EXU_OP_ADD, JMP_NONE, 3'd0, 32'd1, 32'd1, 0, 0, 1, 5'd9, 32'd2, 1, 0, 0, 1), "after_rst_add");

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
